// File: rtl/cpu24_pkg.sv
// Shared constants, op encodings, FSM states and small helpers for the 24-bit datapath.
package cpu24_pkg;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Magnitude of a value, treating it as two's complement only when requested.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the register file, the mul/div unit and write-back.
interface mul_div_unit_if;
    import cpu24_pkg::*;

    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ResultLo;
    logic [WIDTH-1:0] ResultHi;
    logic             DivByZero;

    modport master (
        output Start, Op, OperandA, OperandB,
        input  Busy, Done, ResultLo, ResultHi, DivByZero
    );

    modport slave (
        input  Start, Op, OperandA, OperandB,
        output Busy, Done, ResultLo, ResultHi, DivByZero
    );

endinterface

// File: rtl/mul_div_step.sv
// One iteration of the unsigned shift-add multiply or restoring shift-subtract divide.
// Accumulator layout: multiply {partial_hi, multiplier_lo}; divide {remainder, dividend/quotient}.
module mul_div_step
    import cpu24_pkg::*;
(
    input  logic             i_is_div,
    input  logic [ACC_W-1:0] i_acc,
    input  logic [WIDTH-1:0] i_m,
    output logic [ACC_W-1:0] o_acc_c
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_trial;

    assign w_sum    = {1'b0, i_acc[ACC_W-1:WIDTH]} + {1'b0, i_m};
    assign w_rem_sh = i_acc[ACC_W-1:WIDTH-1];
    assign w_trial  = w_rem_sh - {1'b0, i_m};

    // Select the next accumulator: restore on borrow for divide, add-if-lsb for multiply.
    always_comb begin
        o_acc_c = i_acc;
        if (i_is_div) begin
            if (!w_trial[WIDTH]) begin
                o_acc_c = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc_c = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (i_acc[0]) begin
                o_acc_c = {w_sum, i_acc[WIDTH-1:1]};
            end else begin
                o_acc_c = {1'b0, i_acc[ACC_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 24-bit multiply/divide unit: magnitudes in, WIDTH iterations, sign fix-up, result hold.
module mul_div_unit
    import cpu24_pkg::*;
(
    input  logic           Clock,
    input  logic           Reset,
    mul_div_unit_if.slave  bus
);

    state_e           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_is_div;
    logic             r_sgn_q;
    logic             r_sgn_r;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_a_raw;
    logic [ACC_W-1:0] r_acc;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;

    logic             w_is_div;
    logic             w_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_is_div = (bus.Op == OP_DIVU) || (bus.Op == OP_DIV);
    assign w_signed = (bus.Op == OP_MUL)  || (bus.Op == OP_DIV);
    assign w_sa     = w_signed & bus.OperandA[WIDTH-1];
    assign w_sb     = w_signed & bus.OperandB[WIDTH-1];
    assign w_mag_a  = mag(bus.OperandA, w_signed);
    assign w_mag_b  = mag(bus.OperandB, w_signed);

    assign w_prod_fix = r_sgn_q ? ACC_W'(-r_acc) : r_acc;
    assign w_quo_fix  = r_sgn_q ? WIDTH'(-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_sgn_r ? WIDTH'(-r_acc[ACC_W-1:WIDTH]) : r_acc[ACC_W-1:WIDTH];

    mul_div_step u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_m      (r_m),
        .o_acc_c  (w_acc_next)
    );

    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.ResultLo  = r_lo;
    assign bus.ResultHi  = r_hi;
    assign bus.DivByZero = r_dbz;

    // Control FSM, iteration counter and registered results.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_sgn_q  <= 1'b0;
            r_sgn_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_m      <= '0;
            r_a_raw  <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.Start) begin
                        r_is_div <= w_is_div;
                        r_sgn_q  <= w_sa ^ w_sb;
                        r_sgn_r  <= w_sa;
                        r_b_zero <= (bus.OperandB == '0);
                        r_a_raw  <= bus.OperandA;
                        r_m      <= w_is_div ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_is_div && r_b_zero) begin
                        r_lo  <= '1;
                        r_hi  <= r_a_raw;
                        r_dbz <= 1'b1;
                    end else if (r_is_div) begin
                        r_lo  <= w_quo_fix;
                        r_hi  <= w_rem_fix;
                        r_dbz <= 1'b0;
                    end else begin
                        r_lo  <= w_prod_fix[WIDTH-1:0];
                        r_hi  <= w_prod_fix[ACC_W-1:WIDTH];
                        r_dbz <= 1'b0;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes model results, a monitor checks each Done.
module tb_mul_div_unit;
    import cpu24_pkg::*;

    typedef struct packed {
        logic [23:0] lo;
        logic [23:0] hi;
        logic        dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_div_unit_if bus();

    mul_div_unit dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b);
        longint sa, sb, p, q, r;
        exp_t e;
        sa = op[0] ? longint'($signed(a)) : longint'(a);
        sb = op[0] ? longint'($signed(b)) : longint'(b);
        e.dbz = 1'b0;
        if (!op[1]) begin
            p    = sa * sb;
            e.lo = p[23:0];
            e.hi = p[47:24];
        end else if (b == 24'd0) begin
            e.lo  = 24'hFFFFFF;
            e.hi  = a;
            e.dbz = 1'b1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            e.lo = q[23:0];
            e.hi = r[23:0];
        end
        return e;
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.Done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected Done: lo=%h hi=%h dbz=%b, none outstanding",
                         bus.ResultLo, bus.ResultHi, bus.DivByZero);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ResultLo", 64'(bus.ResultLo), 64'(mon_e.lo));
                chk("ResultHi", 64'(bus.ResultHi), 64'(mon_e.hi));
                chk("DivByZero", 64'(bus.DivByZero), 64'(mon_e.dbz));
            end
        end
    end

    // Present one Start pulse; record an expectation only if the unit is free to accept it.
    task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b);
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.Op       = op;
        bus.OperandA = a;
        bus.OperandB = b;
        if (!bus.Busy) sb_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (bus.Done) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: Done not seen within 60 cycles, got none, expected pulse", name);
        end
    endtask

    function automatic logic [23:0] pick();
        case ($urandom_range(0, 7))
            0:       return 24'h000000;
            1:       return 24'h800000;
            2:       return 24'hFFFFFF;
            3:       return 24'(($urandom_range(0, 15)));
            default: return 24'($urandom);
        endcase
    endfunction

    int d0;

    initial begin
        bus.Start    = 1'b0;
        bus.Op       = 2'b00;
        bus.OperandA = '0;
        bus.OperandB = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset outputs", 64'({bus.Busy, bus.Done, bus.DivByZero, bus.ResultLo, bus.ResultHi}), 64'd0);
        rst = 1'b0;

        // MULU 3*5 with cycle-exact Busy/Done timing
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = OP_MULU; bus.OperandA = 24'd3; bus.OperandB = 24'd5;
        sb_q.push_back(model(OP_MULU, 24'd3, 24'd5));
        @(negedge clk);
        bus.Start = 1'b0;
        for (int k = 0; k <= 26; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("busy/done k=%0d", k), 64'({bus.Busy, bus.Done}),
                64'({(k <= 24), (k == 25)}));
        end

        // Directed arithmetic corners
        issue(OP_MUL,  24'hFFFFFF, 24'h000002); wait_done("mul -1*2");
        issue(OP_MULU, 24'hFFFFFF, 24'hFFFFFF); wait_done("mulu max");
        issue(OP_DIVU, 24'd100,    24'd7);      wait_done("divu 100/7");
        issue(OP_DIV,  24'hFFFFF9, 24'd2);      wait_done("div -7/2");
        issue(OP_DIVU, 24'd5,      24'd0);      wait_done("divu by 0");
        issue(OP_DIV,  24'hFFFFF0, 24'd0);      wait_done("div neg by 0");
        issue(OP_DIV,  24'h800000, 24'hFFFFFF); wait_done("div min/-1");
        issue(OP_MUL,  24'h800000, 24'h800000); wait_done("mul min*min");

        // Start while busy is ignored
        issue(OP_MULU, 24'd3, 24'd5);
        repeat (4) @(negedge clk);
        bus.Start = 1'b1; bus.Op = OP_DIVU; bus.OperandA = 24'd9; bus.OperandB = 24'd9;
        chk("busy during ignored start", 64'(bus.Busy), 64'd1);
        @(negedge clk);
        bus.Start = 1'b0;
        wait_done("ignored start");

        // Back-to-back start in the DONE cycle; results hold while the next op runs
        issue(OP_MULU, 24'd6, 24'd7);
        wait_done("b2b first");
        bus.Start = 1'b1; bus.Op = OP_MULU; bus.OperandA = 24'd2; bus.OperandB = 24'd2;
        sb_q.push_back(model(OP_MULU, 24'd2, 24'd2));
        @(negedge clk);
        bus.Start = 1'b0;
        chk("b2b busy/done", 64'({bus.Busy, bus.Done}), 64'({1'b1, 1'b0}));
        chk("result held", 64'(bus.ResultLo), 64'd42);
        wait_done("b2b second");

        // Reset mid-run discards the operation
        issue(OP_DIVU, 24'd100, 24'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb_q.delete();
        chk("reset mid-run", 64'({bus.Busy, bus.Done, bus.DivByZero, bus.ResultLo, bus.ResultHi}), 64'd0);
        rst = 1'b0;
        d0 = n_done;
        repeat (30) @(negedge clk);
        chk("no done after reset", 64'(n_done), 64'(d0));
        issue(OP_DIVU, 24'd100, 24'd7); wait_done("after reset");

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
            wait_done("random");
        end

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 24-bit multiply/divide unit directly downstream of the register file.
- Consumes the two register read ports (ReadRS, ReadRT) as operands.
- Produces a 48-bit product, or a quotient/remainder pair, for the write-back path.
- Raises Busy so the control unit stalls the PC while an operation is in flight.

Parameters:
- WIDTH, 24, operand/result width; the iteration count equals WIDTH.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a new operation; sampled only when Busy=0.
- Op  input  2  operation: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- OperandA  input  WIDTH  multiplicand or dividend (from ReadRS).
- OperandB  input  WIDTH  multiplier or divisor (from ReadRT).
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when results become valid.
- ResultLo  output  WIDTH  product[23:0] or quotient.
- ResultHi  output  WIDTH  product[47:24] or remainder.
- DivByZero  output  1  set with Done when a divide has OperandB=0; held with the results.

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - State goes to IDLE.
  - Busy=0, Done=0, ResultLo=0, ResultHi=0, DivByZero=0.
  - Any in-flight operation is discarded and no Done is issued.
- States: IDLE, RUN, FIX, DONE.
- IDLE or DONE, Start=1 at edge E0:
  - Latch Op.
  - Latch |OperandA| and |OperandB|; magnitudes only for signed ops, raw values for unsigned ops.
  - Latch the result signs: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - count=0, go to RUN.
- Start=0 in DONE: go to IDLE at the next edge.
- RUN, one iteration per edge:
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing one quotient bit per edge.
  - After WIDTH edges (E1..E24) go to FIX.
- FIX, edge E25:
  - Apply two's-complement negation per the latched signs.
  - Register ResultHi/ResultLo/DivByZero, go to DONE.
- Busy is high in RUN and FIX, i.e. the cycles after E0 through E25. Busy is a registered output.
- Done is high for exactly the cycle in DONE (the cycle after E25).
- Total latency: Start sampled at E0 -> Done visible after E25 (WIDTH+2 edges).
- Results and DivByZero hold their values until the next FIX edge or reset. They do not change when a new operation starts.
- Start while Busy=1: ignored. Operands and Op are not re-sampled.
- Start in the DONE cycle: accepted. Done still pulses for the finishing operation, and the next operation begins back-to-back.
- Divide by zero:
  - Full latency still applies.
  - DivByZero=1, ResultLo=all ones, ResultHi=OperandA unchanged (signed or not).
- Signed division:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - -2^23 / -1 -> ResultLo=0x800000, ResultHi=0, DivByZero=0.
- MUL signed: full 48-bit two's-complement product. MULU: full 48-bit unsigned product.
- DivByZero=0 for all multiply ops.

Decomposition:
- Shared package cpu24_pkg holds:
  - WIDTH constant (24).
  - Op encodings: OP_MULU, OP_MUL, OP_DIVU, OP_DIV.
  - State enumeration: IDLE, RUN, FIX, DONE.
- Optional sub-module mul_div_step: combinational single-iteration datapath for the shift-add / shift-subtract step, instantiated once.
- FSM, counter, and sign fix-up stay in mul_div_unit.

Test Plan:
1. MULU A=0x000003, B=0x000005, Start at E0 -> Busy high E0+1..E25; Done pulses exactly one cycle after E25; ResultHi=0x000000, ResultLo=0x00000F.
2. MUL A=0xFFFFFF (-1), B=0x000002 -> ResultHi=0xFFFFFF, ResultLo=0xFFFFFE. Also MULU A=B=0xFFFFFF -> ResultHi=0xFFFFFE, ResultLo=0x000001.
3. DIVU A=100, B=7 -> ResultLo=0x00000E, ResultHi=0x000002, DivByZero=0. Also DIV A=0xFFFFF9 (-7), B=2 -> ResultLo=0xFFFFFD, ResultHi=0xFFFFFF.
4. DIVU A=5, B=0 -> after full latency: DivByZero=1, ResultLo=0xFFFFFF, ResultHi=0x000005. Also DIV A=0x800000, B=0xFFFFFF -> ResultLo=0x800000, ResultHi=0.
5. Handshake:
   - Start a MULU 3*5, then pulse Start with new operands at cycle E0+5 -> ignored; result still 0x00000F.
   - Assert Start (MULU 2*2) in the DONE cycle -> Done pulses for the first op, Busy rises next cycle; second Done gives ResultLo=0x000004.
6. Reset during RUN (iteration 10 of DIVU 100/7):
   - Next cycle: Busy=0, Done=0, ResultLo=ResultHi=0, DivByZero=0.
   - No Done pulse in the following 30 cycles.
   - A fresh Start afterwards completes normally.
